// File: rtl/tap_tempo.sv
// Tap-tempo estimator: times intervals between tap edges, averages the recent
// history and converts the average period to beats per minute.
module tap_tempo #(
    parameter int CLK_HZ  = 50000000,
    parameter int BPM_MIN = 30,
    parameter int BPM_MAX = 300
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_tap,
    output logic [33:0] o_period,
    output logic [8:0]  o_bpm,
    output logic        o_valid,
    output logic        o_locked
);

    localparam logic [33:0] TICKS        = 34'(64'(CLK_HZ) * 64'd60);
    localparam logic [33:0] MAX_PERIOD   = 34'(64'(TICKS) / 64'(BPM_MIN));
    localparam logic [33:0] MIN_PERIOD   = 34'(64'(TICKS) / 64'(BPM_MAX));
    localparam logic [33:0] RESET_PERIOD = 34'(64'(TICKS) / 64'd120);
    localparam logic [8:0]  RESET_BPM    = 9'd120;
    localparam logic [33:0] BPM_MIN_Q    = 34'(BPM_MIN);
    localparam logic [33:0] BPM_MAX_Q    = 34'(BPM_MAX);
    localparam logic [5:0]  DIV_STEPS    = 6'd34;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_MEASURE = 2'd1;
    localparam logic [1:0] S_CALC    = 2'd2;

    // A shorter minimum period could let a tap be accepted while the divider is busy.
    generate
        if (MIN_PERIOD <= 34'd40) begin : g_minPeriodCheck
            $error("tap_tempo: MIN_PERIOD must exceed 40 clock cycles");
        end
    endgenerate

    logic [1:0]  r_state;
    logic        r_tapPrev;
    logic [33:0] r_count;
    logic [33:0] r_hist [0:3];
    logic [2:0]  r_histCount;
    logic [33:0] r_divisor;
    logic [33:0] r_dividend;
    logic [33:0] r_rem;
    logic [33:0] r_quot;
    logic [5:0]  r_iter;

    logic        w_edge;
    logic        w_timeout;
    logic        w_accept;
    logic [33:0] w_countInc;
    logic [2:0]  w_newCount;
    logic [35:0] w_sum;
    logic [33:0] w_avg;
    logic [34:0] w_remShift;
    logic        w_fits;
    logic [33:0] w_remDiff;
    logic [8:0]  w_bpmClamp;

    assign w_edge     = i_tap & ~r_tapPrev;
    assign w_timeout  = (r_state == S_MEASURE) && (r_count >= MAX_PERIOD);
    assign w_accept   = (r_state == S_MEASURE) && w_edge && !w_timeout &&
                        (r_count >= MIN_PERIOD);
    assign w_countInc = (r_count >= MAX_PERIOD) ? MAX_PERIOD : r_count + 34'd1;
    assign w_newCount = (r_histCount == 3'd4) ? 3'd4 : r_histCount + 3'd1;

    // Average is formed from the history as it will look after pushing r_count.
    always_comb begin
        w_sum = '0;
        w_avg = '0;
        case (w_newCount)
            3'd1: begin
                w_sum = {2'b00, r_count};
                w_avg = w_sum[33:0];
            end
            3'd2, 3'd3: begin
                w_sum = {2'b00, r_count} + {2'b00, r_hist[0]};
                w_avg = w_sum[34:1];
            end
            default: begin
                w_sum = {2'b00, r_count} + {2'b00, r_hist[0]} +
                        {2'b00, r_hist[1]} + {2'b00, r_hist[2]};
                w_avg = w_sum[35:2];
            end
        endcase
    end

    // Restoring divider step; the remainder always fits in 34 bits after subtraction.
    assign w_remShift = {r_rem, r_dividend[33]};
    assign w_fits     = (w_remShift >= {1'b0, r_divisor});
    assign w_remDiff  = w_remShift[33:0] - r_divisor;

    always_comb begin
        w_bpmClamp = r_quot[8:0];
        if (r_quot < BPM_MIN_Q) begin
            w_bpmClamp = 9'(BPM_MIN);
        end else if (r_quot > BPM_MAX_Q) begin
            w_bpmClamp = 9'(BPM_MAX);
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            r_tapPrev   <= 1'b0;
            r_count     <= '0;
            r_hist[0]   <= '0;
            r_hist[1]   <= '0;
            r_hist[2]   <= '0;
            r_hist[3]   <= '0;
            r_histCount <= '0;
            r_divisor   <= '0;
            r_dividend  <= '0;
            r_rem       <= '0;
            r_quot      <= '0;
            r_iter      <= '0;
            o_period    <= RESET_PERIOD;
            o_bpm       <= RESET_BPM;
            o_valid     <= 1'b0;
            o_locked    <= 1'b0;
        end else begin
            r_tapPrev <= i_tap;
            o_valid   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_edge) begin
                        r_state <= S_MEASURE;
                        r_count <= 34'd1;
                    end
                end
                S_MEASURE: begin
                    if (w_timeout) begin
                        r_histCount <= '0;
                        o_locked    <= 1'b0;
                        // A coincident edge starts a fresh sequence as its reference.
                        if (w_edge) begin
                            r_count <= 34'd1;
                        end else begin
                            r_count <= '0;
                            r_state <= S_IDLE;
                        end
                    end else if (w_accept) begin
                        r_hist[0]   <= r_count;
                        r_hist[1]   <= r_hist[0];
                        r_hist[2]   <= r_hist[1];
                        r_hist[3]   <= r_hist[2];
                        r_histCount <= w_newCount;
                        r_divisor   <= w_avg;
                        r_dividend  <= TICKS;
                        r_rem       <= '0;
                        r_quot      <= '0;
                        r_iter      <= '0;
                        r_count     <= 34'd1;
                        r_state     <= S_CALC;
                    end else begin
                        r_count <= w_countInc;
                    end
                end
                S_CALC: begin
                    r_count <= w_countInc;
                    if (r_iter == DIV_STEPS) begin
                        o_period <= r_divisor;
                        o_bpm    <= w_bpmClamp;
                        o_valid  <= 1'b1;
                        o_locked <= 1'b1;
                        r_state  <= S_MEASURE;
                    end else begin
                        r_rem      <= w_fits ? w_remDiff : w_remShift[33:0];
                        r_quot     <= {r_quot[32:0], w_fits};
                        r_dividend <= {r_dividend[32:0], 1'b0};
                        r_iter     <= r_iter + 6'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/tap_tempo.md
TAP_TEMPO -- requirements
Module: tap_tempo

Interface
REQ-001 Parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 Parameter BPM_MIN, default 30, slowest accepted tempo.
REQ-003 Parameter BPM_MAX, default 300, fastest accepted tempo.
REQ-004 Derived constants SHALL be: TICKS = CLK_HZ*60, MAX_PERIOD = TICKS/BPM_MIN, MIN_PERIOD = TICKS/BPM_MAX, all 34-bit unsigned.
REQ-005 i_clk  input  1  single clock; all logic on its rising edge.
REQ-006 i_reset_n  input  1  asynchronous, active-low reset.
REQ-007 i_tap  input  1  synchronous, debounced tap level.
REQ-008 o_period  output  34  averaged beat period in clock cycles.
REQ-009 o_bpm  output  9  tempo in beats per minute, derived from o_period.
REQ-010 o_valid  output  1  one-cycle pulse when o_period/o_bpm update.
REQ-011 o_locked  output  1  high while a tap sequence is in progress and at least one interval has been accepted.

Function
REQ-012 Tap edge SHALL be detected at cycle T when i_tap is 1 at T and was 0 at T-1; the edge register resets to 0.
REQ-013 States SHALL be IDLE (no reference tap), MEASURE (reference tap held, counting), CALC (divider running).
REQ-014 IDLE: tap edge at T1 -> MEASURE, interval counter cleared, no o_valid.
REQ-015 MEASURE: interval = T2 - T1 in cycles for the next tap edge at T2.
REQ-016 Interval < MIN_PERIOD -> edge ignored (bounce), counter keeps running, reference T1 unchanged.
REQ-017 Interval >= MIN_PERIOD and < MAX_PERIOD -> accepted: pushed into a 4-entry interval history; T2 becomes the new reference.
REQ-018 T - T1 reaching MAX_PERIOD with no accepted tap -> timeout: history cleared, o_locked <= 0, -> IDLE. o_period/o_bpm hold.
REQ-019 Tap edge in the same cycle as timeout -> timeout wins; that edge is the new IDLE reference tap (IDLE -> MEASURE).
REQ-020 Average over history count n: n=1 last interval; n=2 sum>>1; n=3 newest two, sum>>1; n=4 sum of four >>2; truncating.
REQ-021 The history sum SHALL be 36 bits wide; no overflow possible.
REQ-022 CALC: o_bpm = floor(TICKS / average) via 34-iteration sequential restoring divider, one quotient bit per cycle.
REQ-023 Quotient SHALL be clamped to [BPM_MIN, BPM_MAX] before driving o_bpm.
REQ-024 Latency: tap edge accepted at T -> o_period, o_bpm, o_valid=1 all updated at T+36 exactly; o_valid low otherwise.
REQ-025 o_locked SHALL rise in the same cycle as the first o_valid of a sequence.
REQ-026 Interval counter continues in CALC, so the next interval is timed from T; CALC returns to MEASURE at T+36.
REQ-027 Elaboration SHALL fail (or assertion fire) if MIN_PERIOD <= 40, ensuring no tap edge is accepted during CALC.
REQ-028 Interval counter SHALL saturate at MAX_PERIOD; it never wraps.

Reset
REQ-029 i_reset_n low SHALL immediately set: state IDLE, history empty, counter 0, o_valid 0, o_locked 0, o_bpm 120, o_period TICKS/120.
REQ-030 Reset during CALC SHALL abort the division; no o_valid after release.
REQ-031 After release, the first tap edge SHALL be a reference tap only.

Verification (CLK_HZ=1000: TICKS=60000, MIN_PERIOD=200, MAX_PERIOD=2000)
REQ-032 Reset then release, no taps -> o_bpm=120, o_period=500, o_valid=0, o_locked=0.
REQ-033 Taps at T=100 and T=600 -> at T=636: o_valid=1, o_period=500, o_bpm=120, o_locked=1.
REQ-034 Intervals 400,600,400,600 -> successive o_period 400,500,500,500; o_bpm 150,120,120,120.
REQ-035 Tap 100 cycles after reference, then tap 500 cycles after reference -> first ignored with no o_valid; then o_period=500.
REQ-036 After lock, no tap for 2000 cycles -> o_locked=0, o_bpm/o_period hold; next tap gives no o_valid.
REQ-037 Interval 150 rejected; interval 1999 -> o_period=1999, o_bpm=30 (clamped). Reset at T+20 of a CALC -> reset values, no o_valid.
